// File: rtl/saph_pkg.sv
// Shared types and helpers for the saph pixel unpack slice.
//   saph_unpack_state_t : frame state machine encoding (IDLE, RUN)
//   saph_msb_align      : left-justifies the low 'width' bits of a field
//                         inside a pack_w-bit bus, zero filling below
package saph_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } saph_unpack_state_t;

  // Working width of the alignment helper; any pack_width up to this fits.
  localparam int SAPH_ALIGN_W = 64;

  function automatic logic [SAPH_ALIGN_W-1:0] saph_msb_align(
    input logic [SAPH_ALIGN_W-1:0] field,
    input int unsigned             pack_w,
    input int unsigned             width
  );
    logic [SAPH_ALIGN_W-1:0] mask;
    mask = (SAPH_ALIGN_W'(1) << width) - SAPH_ALIGN_W'(1);
    return (field & mask) << (pack_w - width);
  endfunction

endpackage

// File: rtl/saph_bit_fifo.sv
// LSB-first bit shift buffer. Words are appended above the current fill
// point; fields are consumed from bit 0. A consume and an append in the
// same cycle shift first, then place the word at the reduced fill point.
// Bits at and above 'fill' are always zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop all buffered bits (wins over push/pop)
//   push        : append push_data at the fill point
//   push_data   : word_width-bit word
//   pop         : consume pop_width bits from bit 0
//   pop_width   : number of bits consumed by pop
//   peek        : oldest peek_w bits of the buffer
//   fill        : number of valid bits held (0..depth)
module saph_bit_fifo #(
  parameter int word_width = 32,
  parameter int depth      = 64,
  parameter int pop_w      = 4,
  parameter int peek_w     = 8,
  parameter int fill_w     = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [word_width-1:0] push_data,
  input  logic                  pop,
  input  logic [pop_w-1:0]      pop_width,
  output logic [peek_w-1:0]     peek,
  output logic [fill_w-1:0]     fill
);

  logic [depth-1:0]  buf_q;
  logic [depth-1:0]  shifted;
  logic [depth-1:0]  word_ext;
  logic [fill_w-1:0] fill_q;
  logic [fill_w-1:0] fill_after;

  always_comb begin
    shifted    = buf_q;
    fill_after = fill_q;
    if (pop) begin
      shifted    = buf_q >> pop_width;
      fill_after = fill_q - fill_w'(pop_width);
    end
    word_ext = '0;
    word_ext[word_width-1:0] = push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (push) begin
      buf_q  <= shifted | (word_ext << fill_after);
      fill_q <= fill_after + fill_w'(word_width);
    end else begin
      buf_q  <= shifted;
      fill_q <= fill_after;
    end
  end

  assign peek = buf_q[peek_w-1:0];
  assign fill = fill_q;

endmodule

// File: rtl/saph_pix_unpack.sv
// Stream field extractor feeding the variable-width bit expander. Accepts
// word_width-bit memory words, slices them LSB-first into fields of the
// width latched at frame start (fields may straddle words) and emits each
// field MSB-aligned on a pack_width-bit bus. One frame = cfg_count fields.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle frame start, ignored while busy
//   cfg_width, cfg_count  : field width / field count, sampled on start
//   busy                  : frame in progress
//   in_data/in_valid/in_ready    : word input handshake
//   out_data/out_width/out_valid/out_ready : field output handshake
// Optional build macro SAPH_PIX_UNPACK_LAST_EN adds:
//   out_last : marks the final field of a frame
//   abort    : ends the current frame next cycle, discarding buffered bits
module saph_pix_unpack #(
  parameter  int word_width = 32,
  parameter  int pack_width = 8,
  parameter  int cnt_width  = 16,
  localparam int pack_exp   = $clog2(pack_width + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [pack_exp-1:0]   cfg_width,
  input  logic [cnt_width-1:0]  cfg_count,
  output logic                  busy,
  input  logic [word_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [pack_width-1:0] out_data,
  output logic [pack_exp-1:0]   out_width,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SAPH_PIX_UNPACK_LAST_EN
  ,
  output logic                  out_last,
  input  logic                  abort
`endif
);

  import saph_pkg::*;

  localparam int depth  = 2 * word_width;
  localparam int fill_w = $clog2(depth + 1);
  localparam int bl_w   = cnt_width + pack_exp;

  saph_unpack_state_t state_q, state_d;

  logic [pack_exp-1:0]   width_q;
  logic [cnt_width-1:0]  remaining_q;
  logic [bl_w-1:0]       bits_left_q;
  logic [pack_width-1:0] peek;
  logic [fill_w-1:0]     fill;
  logic                  run;
  logic                  start_ok;
  logic                  abort_now;
  logic                  in_hs;
  logic                  out_hs;
  logic                  last_hs;
  logic                  frame_end;

`ifdef SAPH_PIX_UNPACK_LAST_EN
  assign abort_now = run && abort;
  assign out_last  = out_valid && (remaining_q == cnt_width'(1));
`else
  assign abort_now = 1'b0;
`endif

  assign run      = (state_q == RUN);
  assign busy     = run;
  assign start_ok = start && (cfg_width != '0) &&
                    (cfg_width <= pack_exp'(pack_width)) && (cfg_count != '0);

  // Only words the frame still needs are taken, and only when a full word
  // fits on top of what is buffered.
  assign in_ready  = run && (bits_left_q != '0) &&
                     (fill <= fill_w'(word_width)) && !abort_now;
  assign out_valid = run && (fill >= fill_w'(width_q));

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready && !abort_now;
  assign last_hs   = out_hs && (remaining_q == cnt_width'(1));
  assign frame_end = last_hs || abort_now;

  // The buffer is zero outside a frame, so out_data reads zero when idle.
  assign out_data  = pack_width'(saph_msb_align(SAPH_ALIGN_W'(peek),
                                                unsigned'(pack_width),
                                                32'(width_q)));
  assign out_width = width_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok)  state_d = RUN;
      RUN:  if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q     <= '0;
      remaining_q <= '0;
      bits_left_q <= '0;
    end else if (state_q == IDLE) begin
      if (start_ok) begin
        width_q     <= cfg_width;
        remaining_q <= cfg_count;
        bits_left_q <= bl_w'(cfg_count) * bl_w'(cfg_width);
      end
    end else if (frame_end) begin
      remaining_q <= '0;
      bits_left_q <= '0;
    end else begin
      if (in_hs)
        bits_left_q <= (bits_left_q > bl_w'(word_width)) ?
                       bits_left_q - bl_w'(word_width) : '0;
      if (out_hs)
        remaining_q <= remaining_q - cnt_width'(1);
    end
  end

  saph_bit_fifo #(
    .word_width (word_width),
    .depth      (depth),
    .pop_w      (pack_exp),
    .peek_w     (pack_width),
    .fill_w     (fill_w)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (frame_end),
    .push       (in_hs),
    .push_data  (in_data),
    .pop        (out_hs),
    .pop_width  (width_q),
    .peek       (peek),
    .fill       (fill)
  );

endmodule

// File: tb/tb_saph_pix_unpack.sv
module tb_saph_pix_unpack;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_width;
  logic [15:0] cfg_count;
  logic        busy;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_width;
  logic        out_valid;
  logic        out_ready;
`ifdef SAPH_PIX_UNPACK_LAST_EN
  logic        out_last;
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  saph_pix_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_count (cfg_count),
    .busy      (busy),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_width (out_width),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SAPH_PIX_UNPACK_LAST_EN
    ,
    .out_last  (out_last),
    .abort     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] w, input logic [15:0] c);
    cfg_width = w;
    cfg_count = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_count = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SAPH_PIX_UNPACK_LAST_EN
    abort = 1'b0;
`endif
    #12;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== 8'h00 || out_width !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b out_data=%h out_width=%0d required all zero",
               busy, in_ready, out_valid, out_data, out_width);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_w4;
    logic [7:0] exp [8];
    int k, acc, first, last;
    exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    k = 0; acc = 0; first = -1; last = -1;
    start_frame(4'd4, 16'd8);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL w4_frame_start: busy=%b in_ready=%b out_valid=%b required 1 1 0", busy, in_ready, out_valid);
    end
    in_data = 32'h87654321; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 8 || out_data !== exp[k] || out_width !== 4'd4) begin
          errors++;
          $display("FAIL w4_field%0d: out_data=%h out_width=%0d required %h width 4", k, out_data, out_width, (k < 8) ? exp[k] : 8'hxx);
        end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (k != 8 || acc != 1 || (last - first) != 7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL w4_frame: fields=%0d words=%0d span=%0d busy=%b required 8 1 7 0", k, acc, last - first, busy);
    end
  endtask

  task automatic test_straddle_w3;
    logic [31:0] words [2];
    logic [7:0]  exp [11];
    int k, acc, widx, extra;
    logic acc_now;
    words = '{32'hFFFFFFFF, 32'hFFFFFFFE};
    for (int i = 0; i < 10; i++) exp[i] = 8'hE0;
    exp[10] = 8'h60;
    k = 0; acc = 0; widx = 0; extra = 0;
    start_frame(4'd3, 16'd11);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      in_data = (widx < 2) ? words[widx] : 32'hDEADBEEF;
      #1;
      acc_now = in_valid && in_ready;
      if (acc_now) acc++;
      if (widx >= 2 && in_ready) extra++;
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 11 || out_data !== exp[k]) begin
          errors++;
          $display("FAIL w3_field%0d: out_data=%h required %h", k, out_data, (k < 11) ? exp[k] : 8'hxx);
        end
        k++;
      end
      tick();
      if (acc_now) widx++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 11 || acc != 2 || extra != 0) begin
      errors++;
      $display("FAIL w3_frame: fields=%0d words=%0d in_ready_after_last_word=%0d required 11 2 0", k, acc, extra);
    end
  endtask

  task automatic test_stall_w8;
    logic [7:0] exp [4];
    logic [7:0] hold;
    int k, acc, viol, stalls;
    logic have_hold;
    exp = '{8'h21, 8'h43, 8'h65, 8'h87};
    k = 0; acc = 0; viol = 0; stalls = 0; have_hold = 1'b0; hold = '0;
    start_frame(4'd8, 16'd4);
    in_data = 32'h87654321; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      // start held high throughout the run, including the last handshake
      start = 1'b1; cfg_width = 4'd4; cfg_count = 16'd8;
      out_ready = (cyc % 2 == 0);
      #1;
      if (acc >= 1 && in_ready) viol++;
      if (in_valid && in_ready) acc++;
      if (have_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold || out_width !== 4'd8) begin
          errors++;
          $display("FAIL w8_stall_hold: out_valid=%b out_data=%h out_width=%0d required 1 %h 8", out_valid, out_data, out_width, hold);
        end
        have_hold = 1'b0;
      end
      if (out_valid && !out_ready) begin
        have_hold = 1'b1; hold = out_data; stalls++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 4 || out_data !== exp[k]) begin
          errors++;
          $display("FAIL w8_field%0d: out_data=%h required %h", k, out_data, (k < 4) ? exp[k] : 8'hxx);
        end
        k++;
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (k != 4 || acc != 1 || viol != 0 || stalls != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL w8_frame: fields=%0d words=%0d in_ready_late=%0d stalls=%0d busy=%b required 4 1 0 4 0",
               k, acc, viol, stalls, busy);
    end
  endtask

  task automatic test_bad_cfg;
    logic [3:0]  ws [3];
    logic [15:0] cs [3];
    ws = '{4'd0, 4'd9, 4'd4};
    cs = '{16'd4, 16'd4, 16'd0};
    in_valid = 1'b1; in_data = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      start_frame(ws[i], cs[i]);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_cfg%0d: busy=%b in_ready=%b required 0 0", i, busy, in_ready);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_cfg%0d_hold: busy=%b in_ready=%b out_valid=%b required 0 0 0", i, busy, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp [2];
    int k;
    exp = '{8'hB0, 8'hC0};
    k = 0;
    start_frame(4'd4, 16'd8);
    in_data = 32'h87654321; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
      if (out_valid && out_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== 8'h00 || out_width !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b out_data=%h out_width=%0d required all zero",
               busy, in_ready, out_valid, out_data, out_width);
    end
    tick();
    rst_n = 1'b1;
    tick();
    k = 0;
    start_frame(4'd4, 16'd2);
    in_data = 32'h000000CB; in_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && busy; cyc++) begin
      if (out_valid && out_ready) begin
        checks++;
        if (k >= 2 || out_data !== exp[k]) begin
          errors++;
          $display("FAIL fresh_field%0d: out_data=%h required %h", k, out_data, (k < 2) ? exp[k] : 8'hxx);
        end
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (k != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fresh_frame: fields=%0d busy=%b required 2 0", k, busy);
    end
  endtask

`ifdef SAPH_PIX_UNPACK_LAST_EN
  task automatic test_last_abort;
    int k, widx, lasts;
    logic acc_now;
    logic [31:0] words [2];
    words = '{32'h12345678, 32'h0000000F};
    k = 0; widx = 0; lasts = 0;
    start_frame(4'd5, 16'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && busy; cyc++) begin
      in_data = (widx < 2) ? words[widx] : 32'h0;
      #1;
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (out_last !== (k == 6)) begin
          errors++;
          $display("FAIL last_field%0d: out_last=%b required %b", k, out_last, (k == 6));
        end
        if (out_last) lasts++;
        k++;
      end
      tick();
      if (acc_now) widx++;
    end
    checks++;
    if (k != 7 || lasts != 1 || widx != 2) begin
      errors++;
      $display("FAIL last_frame: fields=%0d lasts=%0d words=%0d required 7 1 2", k, lasts, widx);
    end
    start_frame(4'd5, 16'd7);
    in_data = words[0];
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort: out_valid=%b busy=%b in_ready=%b required 0 0 0", out_valid, busy, in_ready);
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_w4();
    test_straddle_w3();
    test_stall_w8();
    test_bad_cfg();
    test_reset_midframe();
`ifdef SAPH_PIX_UNPACK_LAST_EN
    test_last_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
